// File: rtl/dsiq_pkg.sv
// -----------------------------------------------------------------------------
// dsiq_pkg
// Shared definitions for the downstream TX I/Q sample packer:
//   - byte index positions within a 4-byte I/Q sample
//   - prime state encoding (IDLE / STREAM)
//   - 35-bit FIFO word layout: {user[2:0], iq[31:0]}
// -----------------------------------------------------------------------------
package dsiq_pkg;

    // Byte positions within one sample, in arrival order.
    localparam logic [1:0] IDX_I1 = 2'd0;
    localparam logic [1:0] IDX_I0 = 2'd1;
    localparam logic [1:0] IDX_Q1 = 2'd2;
    localparam logic [1:0] IDX_Q0 = 2'd3;

    // Prime state encoding.
    localparam logic PRIME_IDLE   = 1'b0;
    localparam logic PRIME_STREAM = 1'b1;

    typedef enum logic {
        StIdle   = PRIME_IDLE,
        StStream = PRIME_STREAM
    } prime_state_e;

    // FIFO word layout.
    localparam int unsigned IQ_W     = 32;
    localparam int unsigned USER_W   = 3;
    localparam int unsigned WORD_W   = IQ_W + USER_W;
    localparam int unsigned USER_LSB = IQ_W;

    typedef struct packed {
        logic [2:0]  user;  // {cw1, cw0, ptt}
        logic [31:0] iq;    // {I[15:0], Q[15:0]}
    } sample_t;

endpackage

// File: rtl/dsiq_sfifo.sv
// -----------------------------------------------------------------------------
// dsiq_sfifo
// Generic synchronous first-word-fall-through FIFO with a registered head.
// Pointers carry one extra MSB so full and empty are distinguishable.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_flush        synchronous clear of both pointers
//   i_push/i_wdata write request and data
//   i_pop          read request (ignored when empty)
//   o_rdata        head word, valid whenever o_empty=0
//   o_empty/o_full status
//   o_fill         current word count
//   o_drop         push refused because full with no simultaneous pop
// -----------------------------------------------------------------------------
module dsiq_sfifo #(
    parameter int unsigned WIDTH      = 35,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_fill,
    output logic                  o_drop
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0]    r_head;
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] w_rd_ptr_nxt;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                  (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
        w_pop   = i_pop & ~w_empty;
        // A pop frees the slot the push needs, so push at full is fine with a pop.
        w_push  = i_push & (~w_full | w_pop);
        w_rd_ptr_nxt = r_rd_ptr + {{DEPTH_LOG2{1'b0}}, w_pop};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wdata;
    end

    // Head register tracks mem[rd_ptr]; bypass the write when the incoming
    // word is the one that will sit at the head.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head <= '0;
        end else if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            r_head <= i_wdata;
        end else begin
            r_head <= r_mem[w_rd_ptr_nxt[DEPTH_LOG2-1:0]];
        end
    end

    assign o_rdata = r_head;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_fill  = r_wr_ptr - r_rd_ptr;
    assign o_drop  = i_push & w_full & ~w_pop;

endmodule

// File: rtl/dsiq_sample_packer.sv
// -----------------------------------------------------------------------------
// dsiq_sample_packer
// Packs the TX I/Q byte stream (I1,I0,Q1,Q0) into 32-bit samples with three
// sideband bits, buffers them and presents them on a valid/ready interface.
// Output starts only after PRIME_LEVEL samples are buffered, or immediately
// after a ptt=0 sample (end of transmit). PRIME_LEVEL must be < 2**DEPTH_LOG2.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   dseth_tdata                 shared downstream byte bus
//   dsethiq_tvalid/tlast/tuser  I/Q byte strobe, last byte (Q0), sideband bit
//   flush                       synchronous clear of FIFO, packer and prime state
//   out_tdata/tuser/tvalid      sample {I,Q}, {cw1,cw0,ptt}, valid
//   out_tready                  consumer accept
//   fill                        buffered sample count
//   overflow                    sticky: a complete sample was dropped
//   underflow_cnt               saturating starved-consumer cycle count
//   frame_err_cnt               saturating malformed sample count
// -----------------------------------------------------------------------------
module dsiq_sample_packer
    import dsiq_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned PRIME_LEVEL = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          dseth_tdata,
    input  logic                dsethiq_tvalid,
    input  logic                dsethiq_tlast,
    input  logic                dsethiq_tuser,
    input  logic                flush,
    output logic [31:0]         out_tdata,
    output logic [2:0]          out_tuser,
    output logic                out_tvalid,
    input  logic                out_tready,
    output logic [DEPTH_LOG2:0] fill,
    output logic                overflow,
    output logic [15:0]         underflow_cnt,
    output logic [7:0]          frame_err_cnt
);

    localparam logic [DEPTH_LOG2:0] PRIME_FILL = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
    localparam logic [DEPTH_LOG2:0] FILL_ONE   = (DEPTH_LOG2 + 1)'(1);

    logic [1:0]          r_idx;
    logic [7:0]          r_i_hi;
    logic [7:0]          r_i_lo;
    logic [7:0]          r_q_hi;
    logic                r_ptt;
    logic                r_cw0;
    logic                r_cw1;
    logic                r_overflow;
    logic [15:0]         r_underflow_cnt;
    logic [7:0]          r_frame_err_cnt;
    prime_state_e        r_state;
    prime_state_e        w_state_d;

    logic                w_byte;
    logic                w_at_q0;
    logic                w_push;
    logic                w_frame_err;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic                w_drop;
    logic                w_underflow;
    logic [DEPTH_LOG2:0] w_fill;
    sample_t             w_wsample;
    sample_t             w_rsample;

    // A byte coincident with flush is discarded.
    assign w_byte      = dsethiq_tvalid & ~flush;
    assign w_at_q0     = (r_idx == IDX_Q0);
    assign w_push      = w_byte & w_at_q0 & dsethiq_tlast;
    // Error when tlast is missing at Q0 or arrives early.
    assign w_frame_err = w_byte & (w_at_q0 ^ dsethiq_tlast);

    assign w_wsample.iq   = {r_i_hi, r_i_lo, r_q_hi, dseth_tdata};
    assign w_wsample.user = {r_cw1, r_cw0, r_ptt};

    // Byte assembler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= IDX_I1;
            r_i_hi <= '0;
            r_i_lo <= '0;
            r_q_hi <= '0;
            r_ptt  <= 1'b0;
            r_cw0  <= 1'b0;
            r_cw1  <= 1'b0;
        end else if (flush) begin
            r_idx <= IDX_I1;
        end else if (dsethiq_tvalid) begin
            r_idx <= (dsethiq_tlast || w_at_q0) ? IDX_I1 : r_idx + 2'd1;
            unique case (r_idx)
                IDX_I1: begin r_i_hi <= dseth_tdata; r_ptt <= dsethiq_tuser; end
                IDX_I0: begin r_i_lo <= dseth_tdata; r_cw0 <= dsethiq_tuser; end
                IDX_Q1: begin r_q_hi <= dseth_tdata; r_cw1 <= dsethiq_tuser; end
                IDX_Q0: ;
            endcase
        end
    end

    dsiq_sfifo #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_wdata (w_wsample),
        .i_pop   (w_pop),
        .o_rdata (w_rsample),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_fill  (w_fill),
        .o_drop  (w_drop)
    );

    assign out_tvalid = (r_state == StStream) & ~w_empty;
    assign w_pop      = out_tvalid & out_tready;
    assign w_underflow = (r_state == StStream) & w_empty & out_tready;

    // Prime state machine
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                // ptt=0 means transmit ended: drain without waiting for the prime level.
                if ((w_fill >= PRIME_FILL) || (w_push && !r_ptt)) w_state_d = StStream;
            end
            StStream: begin
                if (w_pop && (w_fill == FILL_ONE) && !w_push) w_state_d = StIdle;
            end
        endcase
        if (flush) w_state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Status: overflow is sticky until reset, counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow      <= 1'b0;
            r_underflow_cnt <= '0;
            r_frame_err_cnt <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_underflow && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
            if (w_frame_err && (r_frame_err_cnt != 8'hFF)) begin
                r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
            end
        end
    end

    assign out_tdata     = w_rsample.iq;
    assign out_tuser     = w_rsample.user;
    assign fill          = w_fill;
    assign overflow      = r_overflow;
    assign underflow_cnt = r_underflow_cnt;
    assign frame_err_cnt = r_frame_err_cnt;

endmodule

// File: tb/tb_dsiq_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_dsiq_sample_packer
// Scoreboard bench: the stimulus thread pushes expected samples into exp_q as
// each sample completes; a monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_dsiq_sample_packer;

    localparam int unsigned DL2   = 3;
    localparam int unsigned PL    = 4;
    localparam int          DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   dseth_tdata;
    logic         dsethiq_tvalid;
    logic         dsethiq_tlast;
    logic         dsethiq_tuser;
    logic         flush;
    logic [31:0]  out_tdata;
    logic [2:0]   out_tuser;
    logic         out_tvalid;
    logic         out_tready;
    logic [DL2:0] fill;
    logic         overflow;
    logic [15:0]  underflow_cnt;
    logic [7:0]   frame_err_cnt;

    dsiq_sample_packer #(
        .DEPTH_LOG2  (DL2),
        .PRIME_LEVEL (PL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dseth_tdata    (dseth_tdata),
        .dsethiq_tvalid (dsethiq_tvalid),
        .dsethiq_tlast  (dsethiq_tlast),
        .dsethiq_tuser  (dsethiq_tuser),
        .flush          (flush),
        .out_tdata      (out_tdata),
        .out_tuser      (out_tuser),
        .out_tvalid     (out_tvalid),
        .out_tready     (out_tready),
        .fill           (fill),
        .overflow       (overflow),
        .underflow_cnt  (underflow_cnt),
        .frame_err_cnt  (frame_err_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [34:0] exp_q[$];
    int          model_ferr = 0;
    bit          exp_drop = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: each handshake must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h want no sample", {out_tuser, out_tdata});
            end else begin
                chk("pop_data", 64'({out_tuser, out_tdata}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic u, input logic l);
        dseth_tdata    = d;
        dsethiq_tuser  = u;
        dsethiq_tlast  = l;
        dsethiq_tvalid = 1'b1;
        @(posedge clk);
        #1;
        dsethiq_tvalid = 1'b0;
        dsethiq_tlast  = 1'b0;
        dsethiq_tuser  = 1'b0;
        dseth_tdata    = 8'($urandom);
    endtask

    // Well-formed sample; the model keeps it unless the buffer already holds DEPTH.
    task automatic send_sample(input logic [31:0] iq, input logic [2:0] user, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 3));
            send_byte(iq[31-8*b -: 8], (b < 3) ? user[b] : 1'($urandom), b == 3);
        end
        if (exp_q.size() >= DEPTH) exp_drop = 1'b1;
        else exp_q.push_back({user, iq});
    endtask

    task automatic send_bad(input bit truncated);
        int n;
        n = truncated ? $urandom_range(1, 3) : 4;
        for (int b = 0; b < n; b++) begin
            send_byte(8'($urandom), 1'($urandom), truncated && (b == n - 1));
        end
        if (model_ferr < 255) model_ferr++;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fill != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s: timeout fill=%0d queued=%0d want 0", name, fill, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        dseth_tdata = 8'h00;
        dsethiq_tvalid = 1'b0;
        dsethiq_tlast = 1'b0;
        dsethiq_tuser = 1'b0;
        flush = 1'b0;
        out_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_tvalid", 64'(out_tvalid), 64'(0));
        chk("rst_tdata", 64'(out_tdata), 64'(0));
        chk("rst_tuser", 64'(out_tuser), 64'(0));
        chk("rst_fill", 64'(fill), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_ferr", 64'(frame_err_cnt), 64'(0));
        chk("rst_uflow", 64'(underflow_cnt), 64'(0));

        // Priming: nothing until the prime level is reached
        for (int k = 0; k < 3; k++) begin
            send_sample(32'h12345678, 3'b001, 1'b0);
            chk("prime_hold", 64'(out_tvalid), 64'(0));
        end
        send_sample(32'h12345678, 3'b001, 1'b0);
        idle(2);
        chk("prime_valid", 64'(out_tvalid), 64'(1));
        chk("prime_data", 64'(out_tdata), 64'(32'h12345678));
        chk("prime_user", 64'(out_tuser), 64'(3'b001));
        chk("prime_fill", 64'(fill), 64'(4));
        out_tready = 1'b1;
        wait_empty("drain1");
        idle(5);
        chk("uflow_zero", 64'(underflow_cnt), 64'(0));
        chk("idle_after_drain", 64'(out_tvalid), 64'(0));

        // Framing errors and ptt=0 immediate drain
        out_tready = 1'b0;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b0, 1'b1);
        model_ferr++;
        chk("ferr_early_last", 64'(frame_err_cnt), 64'(model_ferr));
        chk("ferr_fill", 64'(fill), 64'(0));
        send_sample(32'hABCDEF01, 3'b000, 1'b0);
        chk("ptt0_valid", 64'(out_tvalid), 64'(1));
        chk("ptt0_data", 64'(out_tdata), 64'(32'hABCDEF01));
        chk("ptt0_user", 64'(out_tuser[0]), 64'(0));
        send_bad(1'b0);
        chk("ferr_no_last", 64'(frame_err_cnt), 64'(model_ferr));
        chk("ferr_fill2", 64'(fill), 64'(1));
        out_tready = 1'b1;
        wait_empty("drain2");

        // cw sideband bits
        out_tready = 1'b0;
        send_sample(32'h0BADF00D, 3'b101, 1'b0);
        for (int k = 0; k < 3; k++) send_sample($urandom, 3'b001, 1'b0);
        idle(2);
        chk("cw_user", 64'(out_tuser), 64'(3'b101));
        out_tready = 1'b1;
        wait_empty("drain_cw");

        // Overflow with a stalled consumer
        chk("ovf_before", 64'(overflow), 64'(0));
        out_tready = 1'b0;
        for (int k = 0; k < 10; k++) send_sample($urandom, 3'($urandom), 1'b0);
        chk("ovf_fill", 64'(fill), 64'(DEPTH));
        chk("ovf_flag", 64'(overflow), 64'(exp_drop));
        out_tready = 1'b1;
        wait_empty("drain_ovf");

        // Randomized traffic with gaps, random backpressure and bad frames
        for (int k = 0; k < 60; k++) begin
            out_tready = ($urandom_range(0, 3) != 0);
            if (exp_q.size() >= DEPTH - 1) begin
                int n;
                n = 0;
                out_tready = 1'b1;
                while (exp_q.size() >= DEPTH - 1 && n < 100) begin
                    idle(1);
                    n++;
                end
            end
            if ($urandom_range(0, 7) == 0) send_bad($urandom_range(0, 1) == 1);
            else send_sample($urandom, {2'($urandom), 1'($urandom_range(0, 4) != 0)}, 1'b1);
        end
        send_sample($urandom, 3'b000, 1'b0);
        out_tready = 1'b1;
        wait_empty("drain_rand");
        chk("rand_ferr", 64'(frame_err_cnt), 64'(model_ferr));
        chk("rand_uflow", 64'(underflow_cnt), 64'(0));

        // Flush mid-sample, with a byte on the flush cycle
        out_tready = 1'b0;
        send_sample(32'h55667788, 3'b001, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        dseth_tdata = 8'h33;
        dsethiq_tvalid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        dsethiq_tvalid = 1'b0;
        exp_q.delete();
        send_sample(32'hCAFEBABE, 3'b001, 1'b0);
        chk("flush_fill", 64'(fill), 64'(1));
        chk("flush_ferr", 64'(frame_err_cnt), 64'(model_ferr));
        chk("flush_ovf", 64'(overflow), 64'(1));
        chk("flush_idle", 64'(out_tvalid), 64'(0));
        send_sample(32'h01020304, 3'b000, 1'b0);
        chk("flush_ptt0_valid", 64'(out_tvalid), 64'(1));
        chk("flush_head", 64'(out_tdata), 64'(32'hCAFEBABE));

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        exp_q.delete();
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(out_tvalid), 64'(0));
        chk("arst_tdata", 64'(out_tdata), 64'(0));
        chk("arst_tuser", 64'(out_tuser), 64'(0));
        chk("arst_fill", 64'(fill), 64'(0));
        chk("arst_ovf", 64'(overflow), 64'(0));
        chk("arst_ferr", 64'(frame_err_cnt), 64'(0));
        chk("arst_uflow", 64'(underflow_cnt), 64'(0));
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
